mult_accumulate_sequencer: RTL and testbench
============================================

MULT_ACCUMULATE_SEQUENCER -- requirements
Module: mult_accumulate_sequencer

Interface
REQ-001 Parameter N, default 4: signed operand width; the same value as the downstream Booth multiplier's N.
REQ-002 Parameter ACC_W, default 2*N+4: signed accumulator width; SHALL be >= 2*N.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  an operand pair is presented.
REQ-006 in_ready  output  1  the block accepts an operand pair this cycle.
REQ-007 in_a  input  N  signed multiplicand.
REQ-008 in_b  input  N  signed multiplier.
REQ-009 in_last  input  1  the pair is the final term of the current dot product.
REQ-010 mul_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 mul_multiplicand  output  N  operand to the multiplier, held stable from issue through done.
REQ-012 mul_multiplier  output  N  operand to the multiplier, held stable from issue through done.
REQ-013 mul_product  input  2N  signed product from the multiplier; valid only while mul_done=1.
REQ-014 mul_done  input  1  product valid strobe from the multiplier.
REQ-015 acc_valid  output  1  the accumulated result is available.
REQ-016 acc_ready  input  1  the consumer accepts the result.
REQ-017 acc_result  output  ACC_W  signed dot-product sum.
REQ-018 acc_overflow  output  1  sticky flag: signed overflow occurred during the current sum.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT and OUTPUT.
REQ-020 IDLE: in_ready=1; on in_valid, register in_a, in_b and in_last, and go to ISSUE.
REQ-021 ISSUE: mul_start=1 for exactly one cycle, then go to WAIT.
REQ-022 WAIT: mul_start=0; on mul_done, set acc <= acc + sign_extend(mul_product) in that same cycle.
REQ-023 WAIT exit: go to OUTPUT if the registered last flag is 1, else return to IDLE.
REQ-024 OUTPUT: acc_valid=1, with acc_result and acc_overflow held stable.
REQ-025 OUTPUT exit: on acc_ready, clear acc to 0, clear acc_overflow, and go to IDLE.
REQ-026 in_ready SHALL be 0 in every state other than IDLE; no operand pair is accepted while a multiply or an output is pending.
REQ-027 mul_multiplicand and mul_multiplier SHALL be driven from the capture registers and SHALL change only on acceptance in IDLE.
REQ-028 mul_done SHALL be ignored in any state other than WAIT.
REQ-029 In WAIT the block SHALL wait indefinitely for mul_done; there is no timeout.
REQ-030 Accumulation SHALL use two's-complement wrap at ACC_W bits.
REQ-031 acc_overflow SHALL be set when both addends have equal sign and the sum's sign differs, and SHALL stay set until the output handshake.
REQ-032 acc_result SHALL expose the internal accumulator continuously; consumers sample it only while acc_valid=1.
REQ-033 Latency: the acc update is visible the cycle after mul_done; acc_valid asserts in that same cycle for a last pair.
REQ-034 Throughput: one pair per (2 + multiplier latency) cycles.

Reset
REQ-035 With reset high at a rising edge, the state SHALL become IDLE regardless of the current state, including mid-WAIT.
REQ-036 Reset SHALL clear acc, acc_overflow, the capture registers and the last flag to 0.
REQ-037 After reset: mul_start=0, acc_valid=0, acc_result=0, acc_overflow=0, mul_multiplicand=0, mul_multiplier=0, in_ready=1.
REQ-038 Reset SHALL take priority over every other input in the same cycle.

Verification
REQ-039 Reset scenario: hold reset 2 cycles -> all outputs at reset values and in_ready=1 on the first cycle after release.
REQ-040 Single term: N=4, ACC_W=12, pair (3,-2) with last=1 -> mul_start pulses once; acc_valid=1 with acc_result=12'hFFA (-6) and acc_overflow=0.
REQ-041 Dot product: pairs (2,3), (-4,5), (7,7) with last=1 on the third -> acc_result=35; exactly three mul_start pulses.
REQ-042 Overflow: 32 pairs of (-8,-8), last=1 on the 32nd -> acc_result=12'h800 (wrapped) and acc_overflow=1.
REQ-043 Overflow clear: after the REQ-042 handshake, a following sum of (1,1) -> acc_overflow=0.
REQ-044 Backpressure: acc_ready=0 for 5 cycles in OUTPUT -> acc_valid, acc_result and acc_overflow stable, in_ready=0 throughout; the handshake in cycle 6 returns to IDLE with acc=0.
REQ-045 Abort: reset asserted during WAIT, then a stray mul_done -> acc stays 0, no acc_valid, and in_ready=1.

Source files
------------

// File: rtl/mult_accumulate_sequencer.sv
// mult_accumulate_sequencer
//
// Sequences signed operand pairs through an external multi-cycle multiplier
// and accumulates the products into a signed dot-product sum. One pair is in
// flight at a time. The sum is presented with a valid/ready handshake when the
// pair flagged "last" has been accumulated.
//
// Ports
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   in_valid/in_ready             operand pair handshake (in_a, in_b, in_last)
//   mul_start                     one-cycle start pulse to the multiplier
//   mul_multiplicand/multiplier   captured operands, stable from issue to done
//   mul_product/mul_done          signed product and its valid strobe
//   acc_valid/acc_ready           result handshake
//   acc_result                    signed running sum (always visible)
//   acc_overflow                  sticky signed-overflow flag for the current sum
//
// ACC_W must be at least 2*N so that a single product fits without loss.

module mult_accumulate_sequencer #(
    parameter int N     = 4,
    parameter int ACC_W = 2*N+4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     in_a,
    input  logic signed [N-1:0]     in_b,
    input  logic                    in_last,
    output logic                    mul_start,
    output logic signed [N-1:0]     mul_multiplicand,
    output logic signed [N-1:0]     mul_multiplier,
    input  logic signed [2*N-1:0]   mul_product,
    input  logic                    mul_done,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic signed [ACC_W-1:0] acc_result,
    output logic                    acc_overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic signed [N-1:0]     a_q;
    logic signed [N-1:0]     b_q;
    logic                    last_q;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;

    logic                    capture_en;
    logic                    acc_add_en;
    logic                    acc_clr_en;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] sum;

    // A size cast of a signed operand replicates its sign bit.
    function automatic logic signed [ACC_W-1:0] sign_extend(input logic signed [2*N-1:0] p);
        return ACC_W'(p);
    endfunction

    // Two's-complement overflow: like-signed addends giving a differently signed sum.
    function automatic logic add_overflows(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    assign addend = sign_extend(mul_product);
    assign sum    = acc + addend;   // wraps naturally at ACC_W bits

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        mul_start  = 1'b0;
        acc_valid  = 1'b0;
        capture_en = 1'b0;
        acc_add_en = 1'b0;
        acc_clr_en = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    capture_en = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                // No timeout: the multiplier is trusted to answer eventually.
                if (mul_done) begin
                    acc_add_en = 1'b1;
                    state_nxt  = last_q ? OUTPUT : IDLE;
                end
            end
            OUTPUT: begin
                acc_valid = 1'b1;
                if (acc_ready) begin
                    acc_clr_en = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture registers: the multiplier operands change only on acceptance.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_q    <= '0;
            b_q    <= '0;
            last_q <= 1'b0;
        end else if (capture_en) begin
            a_q    <= in_a;
            b_q    <= in_b;
            last_q <= in_last;
        end
    end

    // Accumulator and sticky overflow; both clear on the output handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (acc_add_en) begin
            acc <= sum;
            ovf <= ovf | add_overflows(acc[ACC_W-1], addend[ACC_W-1], sum[ACC_W-1]);
        end else if (acc_clr_en) begin
            acc <= '0;
            ovf <= 1'b0;
        end
    end

    assign mul_multiplicand = a_q;
    assign mul_multiplier   = b_q;
    assign acc_result       = acc;
    assign acc_overflow     = ovf;

endmodule

// File: tb/tb_mult_accumulate_sequencer.sv
`timescale 1ns/1ps

module tb_mult_accumulate_sequencer;

    localparam int N       = 4;
    localparam int ACC_W   = 12;
    localparam int MUL_LAT = 3;

    logic                    clock = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    in_ready;
    logic signed [N-1:0]     in_a = '0;
    logic signed [N-1:0]     in_b = '0;
    logic                    in_last = 1'b0;
    logic                    mul_start;
    logic signed [N-1:0]     mul_multiplicand;
    logic signed [N-1:0]     mul_multiplier;
    logic signed [2*N-1:0]   mul_product;
    logic                    mul_done;
    logic                    acc_valid;
    logic                    acc_ready = 1'b1;
    logic signed [ACC_W-1:0] acc_result;
    logic                    acc_overflow;
    logic                    stray_done = 1'b0;

    always #5 clock = ~clock;

    mult_accumulate_sequencer #(.N(N), .ACC_W(ACC_W)) dut (
        .clock            (clock),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_last          (in_last),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done),
        .acc_valid        (acc_valid),
        .acc_ready        (acc_ready),
        .acc_result       (acc_result),
        .acc_overflow     (acc_overflow)
    );

    // Behavioural multiplier: fixed latency, product driven only with done,
    // a non-zero junk value otherwise.
    logic                  m_busy = 1'b0;
    int                    m_cnt = 0;
    logic                  m_done = 1'b0;
    logic signed [2*N-1:0] m_prod = '0;
    logic signed [N-1:0]   m_a = '0;
    logic signed [N-1:0]   m_b = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (mul_start) begin
                m_busy <= 1'b1;
                m_cnt  <= MUL_LAT;
                m_a    <= mul_multiplicand;
                m_b    <= mul_multiplier;
            end else if (m_busy) begin
                if (m_cnt <= 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= (2*N)'(m_a) * (2*N)'(m_b);
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    assign mul_done    = m_done | stray_done;
    assign mul_product = m_done ? m_prod : 8'sh77;

    typedef struct packed {
        logic [ACC_W-1:0] res;
        logic             ovf;
    } exp_t;

    typedef struct packed {
        logic signed [N-1:0] a;
        logic signed [N-1:0] b;
        logic                last;
        logic [ACC_W-1:0]    exp_acc;
        logic                exp_ovf;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   n_starts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Start pulse counter.
    initial forever begin
        @(negedge clock);
        if (!reset && mul_start) n_starts++;
    end

    // Scoreboard monitor: pops an expected result on every output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset && acc_valid && acc_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0h, no result expected", $unsigned(acc_result));
                end else begin
                    e = sb.pop_front();
                    chk("acc_result", $unsigned(acc_result), e.res);
                    chk("acc_overflow", acc_overflow, e.ovf);
                end
            end
        end
    end

    task automatic send_pair(input logic signed [N-1:0] a, input logic signed [N-1:0] b, input logic last);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        chk("issue_mul_start", mul_start, 1);
        chk("issue_in_ready", in_ready, 0);
        chk("issue_multiplicand", $unsigned(mul_multiplicand), $unsigned(a));
        chk("issue_multiplier", $unsigned(mul_multiplier), $unsigned(b));
        step();
        chk("wait_mul_start", mul_start, 0);
        guard = 0;
        while (!mul_done && guard < 50) begin
            step();
            guard++;
        end
        if (!mul_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout: got 0, expected 1");
        end
        chk("wait_in_ready", in_ready, 0);
        chk("wait_hold_multiplicand", $unsigned(mul_multiplicand), $unsigned(a));
        step();
        chk("post_done_acc_valid", acc_valid, last);
        if (!last) chk("post_done_in_ready", in_ready, 1);
    endtask

    initial begin
        int terms;
        int starts0;
        logic [ACC_W-1:0] held;

        tbl[0] = '{4'sd3,  -4'sd2, 1'b1, 12'hFFA, 1'b0};
        tbl[1] = '{4'sd2,   4'sd3, 1'b0, 12'h000, 1'b0};
        tbl[2] = '{-4'sd4,  4'sd5, 1'b0, 12'h000, 1'b0};
        tbl[3] = '{4'sd7,   4'sd7, 1'b1, 12'h023, 1'b0};
        tbl[4] = '{-4'sd8,  4'sd7, 1'b1, 12'hFC8, 1'b0};
        tbl[5] = '{4'sd7,  -4'sd8, 1'b0, 12'h000, 1'b0};
        tbl[6] = '{-4'sd1, -4'sd1, 1'b1, 12'hFC9, 1'b0};
        tbl[7] = '{-4'sd8, -4'sd8, 1'b1, 12'h040, 1'b0};

        // Reset held for two edges.
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk("rst_mul_start", mul_start, 0);
        chk("rst_acc_valid", acc_valid, 0);
        chk("rst_acc_result", $unsigned(acc_result), 0);
        chk("rst_acc_overflow", acc_overflow, 0);
        chk("rst_multiplicand", $unsigned(mul_multiplicand), 0);
        chk("rst_multiplier", $unsigned(mul_multiplier), 0);
        chk("rst_in_ready", in_ready, 1);

        // Table-driven sums.
        terms   = 0;
        starts0 = n_starts;
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].last) sb.push_back(exp_t'{tbl[i].exp_acc, tbl[i].exp_ovf});
            send_pair(tbl[i].a, tbl[i].b, tbl[i].last);
            terms++;
            if (tbl[i].last) begin
                step();
                chk("start_pulses", n_starts - starts0, terms);
                chk("after_hs_acc_zero", $unsigned(acc_result), 0);
                chk("after_hs_in_ready", in_ready, 1);
                terms   = 0;
                starts0 = n_starts;
            end
        end

        // 32 x (-8*-8) = 2048 wraps to -2048 with overflow.
        starts0 = n_starts;
        for (int i = 0; i < 32; i++) begin
            if (i == 31) sb.push_back(exp_t'{12'h800, 1'b1});
            send_pair(-4'sd8, -4'sd8, i == 31);
        end
        step();
        chk("ovf_start_pulses", n_starts - starts0, 32);
        chk("ovf_cleared_after_hs", acc_overflow, 0);

        // Following sum starts with overflow cleared.
        sb.push_back(exp_t'{12'h001, 1'b0});
        send_pair(4'sd1, 4'sd1, 1'b1);
        step();

        // Overflow stays sticky while later terms are added.
        for (int i = 0; i < 32; i++) send_pair(-4'sd8, -4'sd8, 1'b0);
        sb.push_back(exp_t'{12'h801, 1'b1});
        send_pair(4'sd1, 4'sd1, 1'b1);
        step();

        // Backpressure: result held for five cycles, handshake in the sixth.
        acc_ready = 1'b0;
        sb.push_back(exp_t'{12'h009, 1'b0});
        send_pair(4'sd3, 4'sd3, 1'b1);
        held = acc_result;
        for (int i = 0; i < 5; i++) begin
            chk("bp_acc_valid", acc_valid, 1);
            chk("bp_acc_result", $unsigned(acc_result), 12'h009);
            chk("bp_acc_overflow", acc_overflow, 0);
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        chk("bp_cycle6_valid", acc_valid, 1);
        chk("bp_cycle6_held", $unsigned(acc_result), held);
        acc_ready = 1'b1;
        step();
        chk("bp_release_valid", acc_valid, 0);
        chk("bp_release_acc", $unsigned(acc_result), 0);
        chk("bp_release_in_ready", in_ready, 1);

        // Abort: reset during WAIT (with in_valid also high), then a stray done.
        in_valid = 1'b1;
        in_a     = 4'sd5;
        in_b     = 4'sd5;
        in_last  = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("abort_in_wait", in_ready, 0);
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("abort_rst_in_ready", in_ready, 1);
        chk("abort_rst_multiplicand", $unsigned(mul_multiplicand), 0);
        chk("abort_rst_mul_start", mul_start, 0);
        stray_done = 1'b1;
        step();
        stray_done = 1'b0;
        step();
        chk("abort_acc_zero", $unsigned(acc_result), 0);
        chk("abort_acc_valid", acc_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_overflow", acc_overflow, 0);

        // Recovery after abort.
        sb.push_back(exp_t'{12'hFFA, 1'b0});
        send_pair(4'sd2, -4'sd3, 1'b1);
        step();
        step();
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
